// File: rtl/ram_bank_pipelined.sv
// Bank-addressed synchronous RAM with valid/ready requests, byte enables and a 1/2-cycle read pipe.
// Build option: RAM_CLEAR_EN (zero-fill sweep after reset; req_ready/init_done rise when it ends).
// Ports: clock, reset_n (async, low) | req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//        bank_hit (comb bank match) | rsp_valid, rsp_data (tristate, driven only with rsp_valid) | init_done
module ram_bank_pipelined #(
  parameter int                   DATA_W       = 64,
  parameter int                   DEPTH        = 256,
  parameter int                   ADDR_W       = 64,
  parameter int                   BANK_BITS    = 8,
  parameter logic [BANK_BITS-1:0] BANK_ID      = '0,
  parameter int                   READ_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                bank_hit,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NBYTE = DATA_W / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx;
  logic              acc;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              v1_q;
  logic [DATA_W-1:0] d1_q;
  logic [DATA_W-1:0] rsp_q;

  assign idx      = req_addr[IDX_W-1:0];
  assign bank_hit = (req_addr[ADDR_W-1 -: BANK_BITS] == BANK_ID);
  assign acc      = req_valid & req_ready & bank_hit;
  assign wr_en    = acc & req_write;
  assign rd_en    = acc & ~req_write;

  // Bits between the index and the bank field are don't-care (aliasing).
  generate
    if (ADDR_W - BANK_BITS > IDX_W) begin : g_unused
      logic unused_mid;
      assign unused_mid = ^req_addr[ADDR_W-BANK_BITS-1:IDX_W];
    end
  endgenerate

`ifdef RAM_CLEAR_EN
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end
  end
`else
  // Without the sweep, INIT is a single post-reset cycle with no memory access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT) state_d = ST_RUN;
  end
`endif

  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state_q == ST_RUN) begin
      req_ready = 1'b1;
      init_done = 1'b1;
    end
  end

  // Storage has no reset: contents survive reset_n unless swept.
  always_ff @(posedge clock) begin
`ifdef RAM_CLEAR_EN
    if (state_q == ST_INIT) mem_q[cnt_q] <= '0;
    else
`endif
    if (wr_en) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (req_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) v1_q <= 1'b0;
    else          v1_q <= rd_en;
  end

  always_ff @(posedge clock) begin
    if (rd_en) d1_q <= mem_q[idx];
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) v2_q <= 1'b0;
        else          v2_q <= v1_q;
      end

      always_ff @(posedge clock) begin
        if (v1_q) d2_q <= d1_q;
      end

      assign rsp_valid = v2_q;
      assign rsp_q     = d2_q;
    end else begin : g_lat1
      assign rsp_valid = v1_q;
      assign rsp_q     = d1_q;
    end
  endgenerate

  // Release the shared bus whenever this bank has nothing to return.
  assign rsp_data = rsp_valid ? rsp_q : {DATA_W{1'bz}};

endmodule
